sprite_blitter: RTL

- Per-frame pixel producer that sits between the doodle position logic and the double-buffered framebuffer write port.
- On each frame-start pulse it first clears the whole back buffer to a background colour, then copies one sprite from a synchronous ROM at the latched (Sprite_X, Sprite_Y).
- Output is a one-pixel-per-cycle write stream (draw_x, draw_y, draw_color, wr_en) that feeds the framebuffer x/y/rgb_in inputs.
- Out-of-screen sprite pixels are clipped; transparent sprite texels are skipped.

---
 rtl/sprite_blitter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module  : sprite_blitter
// Purpose : Per-frame back-buffer clear followed by a clipped, transparent-aware
//           sprite copy, emitted as a one-pixel-per-cycle write stream.
// Revision: 1.0
// ============================================================================
module sprite_blitter #(
  parameter int          W           = 320,
  parameter int          H           = 240,
  parameter int          SPR_W       = 32,
  parameter int          SPR_H       = 32,
  parameter logic [7:0]  BG_COLOR    = 8'h00,
  parameter logic [7:0]  TRANSPARENT = 8'hFF,
  localparam int         AW          = $clog2(SPR_W*SPR_H)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_start,
  input  logic [9:0]    Sprite_X,
  input  logic [9:0]    Sprite_Y,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic [9:0]    draw_x,
  output logic [9:0]    draw_y,
  output logic [7:0]    draw_color,
  output logic          wr_en,
  output logic          busy,
  output logic          done
);

  localparam int TXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int TYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [9:0]     CX_LAST = 10'(W - 1);
  localparam logic [9:0]     CY_LAST = 10'(H - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(SPR_W - 1);
  localparam logic [TYW-1:0] TY_LAST = TYW'(SPR_H - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_BLIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         r_state;
  logic [9:0]     r_sx0, r_sy0;
  logic [9:0]     r_cx, r_cy;
  logic [TXW-1:0] r_tx, r_tx_d;
  logic [TYW-1:0] r_ty, r_ty_d;
  logic           r_vld_d;
  logic           r_busy, r_done;
  logic [9:0]     r_last_x, r_last_y;
  logic [7:0]     r_last_c;

  logic [10:0]    w_px, w_py;
  logic           w_blit_wr;
  logic           w_wr;
  logic [9:0]     w_x, w_y;
  logic [7:0]     w_c;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_sx0   <= '0;
      r_sy0   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_tx    <= '0;
      r_ty    <= '0;
      r_tx_d  <= '0;
      r_ty_d  <= '0;
      r_vld_d <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_vld_d <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_sx0   <= Sprite_X;
            r_sy0   <= Sprite_Y;
            r_cx    <= '0;
            r_cy    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_cx == CX_LAST) begin
            r_cx <= '0;
            if (r_cy == CY_LAST) begin
              r_cy    <= '0;
              r_tx    <= '0;
              r_ty    <= '0;
              r_state <= S_BLIT;
            end else begin
              r_cy <= r_cy + 10'd1;
            end
          end else begin
            r_cx <= r_cx + 10'd1;
          end
        end
        S_BLIT: begin
          // Texel coordinates ride alongside the ROM's one-cycle read latency.
          r_tx_d  <= r_tx;
          r_ty_d  <= r_ty;
          r_vld_d <= 1'b1;
          if (r_tx == TX_LAST) begin
            r_tx <= '0;
            if (r_ty == TY_LAST) begin
              r_ty    <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_ty <= r_ty + TYW'(1);
            end
          end else begin
            r_tx <= r_tx + TXW'(1);
          end
        end
        S_DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // 11-bit sums so coordinates past the screen edge clip instead of wrapping.
  always_comb begin
    w_px      = {1'b0, r_sx0} + 11'(r_tx_d);
    w_py      = {1'b0, r_sy0} + 11'(r_ty_d);
    w_blit_wr = r_vld_d && (rom_data != TRANSPARENT) &&
                (w_px < 11'(W)) && (w_py < 11'(H));
    w_wr = (r_state == S_CLEAR);
    w_x  = r_cx;
    w_y  = r_cy;
    w_c  = BG_COLOR;
    if ((r_state == S_BLIT) || (r_state == S_DRAIN)) begin
      w_wr = w_blit_wr;
      w_x  = w_px[9:0];
      w_y  = w_py[9:0];
      w_c  = rom_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_last_x <= '0;
      r_last_y <= '0;
      r_last_c <= '0;
    end else if (w_wr) begin
      r_last_x <= w_x;
      r_last_y <= w_y;
      r_last_c <= w_c;
    end
  end

  assign rom_addr   = AW'(int'(r_ty) * SPR_W + int'(r_tx));
  assign wr_en      = w_wr;
  assign draw_x     = w_wr ? w_x : r_last_x;
  assign draw_y     = w_wr ? w_y : r_last_y;
  assign draw_color = w_wr ? w_c : r_last_c;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire
